key_debounce_arbiter: RTL

- Debounces N raw push-buttons using one shared 20 ms timer instead of one timer per key.
- A round-robin arbiter grants the timer to one key at a time whose raw level differs from its debounced level.
- Produces a debounced level per key plus one-cycle press and release pulses.
- Sits between the board key pins and the display-mode control logic of the VGA monitor design.

---
 rtl/key_debounce_arbiter_if.sv | 24 ++
 rtl/key_debounce_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/key_debounce_arbiter_if.sv
// Key-pad bundle between the board pins and the shared-timer debouncer.
// Latency: n/a (wires only). Backpressure: none; outputs are levels and pulses.
// Ports: key (raw, active-low) | key_level, key_flag, key_rel_flag, busy (results).
interface key_debounce_arbiter_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key;           // raw pins, 0 = pressed
  logic [N_KEYS-1:0] key_level;     // debounced level, 0 = pressed
  logic [N_KEYS-1:0] key_flag;      // one-cycle pulse on debounced press
  logic [N_KEYS-1:0] key_rel_flag;  // one-cycle pulse on debounced release
  logic              busy;          // shared timer is granted

  // Key source side (board / testbench).
  modport master (
    output key,
    input  key_level, key_flag, key_rel_flag, busy
  );

  // Debouncer side.
  modport slave (
    input  key,
    output key_level, key_flag, key_rel_flag, busy
  );
endinterface

// File: rtl/key_debounce_arbiter.sv
// Debounces N_KEYS raw buttons with one shared timer granted round-robin to keys whose level changed.
// Latency: pulse/level change visible after edge T+CNT_MAX+2, T = edge where the synchronized key changes.
// Backpressure: none; waiting keys keep requesting while they differ, one IDLE cycle between grants.
// Ports: clk, rst_n (async, active-low); kb.slave carries key in, key_level/key_flag/key_rel_flag/busy out.
module key_debounce_arbiter #(
  parameter  int N_KEYS  = 4,
  parameter  int CNT_MAX = 999_999,
  localparam int CNT_W   = $clog2(CNT_MAX + 1),
  localparam int PTR_W   = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_debounce_arbiter_if.slave kb
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DEBOUNCE = 1'b1;

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] ks_q, ks_d;
  logic [N_KEYS-1:0] key_level_q, key_level_d;
  logic [N_KEYS-1:0] key_flag_q, key_flag_d;
  logic [N_KEYS-1:0] key_rel_flag_q, key_rel_flag_d;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_KEYS-1:0] req;
  logic              req_found;
  logic [PTR_W-1:0]  req_pick;
  logic [PTR_W-1:0]  gnt_next;
  int                scan_idx;

  // A key wants the timer whenever its synchronized level disagrees with the debounced one.
  assign req = ks_q ^ key_level_q;

  // Round-robin pick: first requesting key at or above rr_ptr, wrapping at N_KEYS.
  always_comb begin
    req_found = 1'b0;
    req_pick  = '0;
    scan_idx  = 0;
    for (int off = 0; off < N_KEYS; off++) begin
      scan_idx = int'(rr_ptr_q) + off;
      if (scan_idx >= N_KEYS) scan_idx = scan_idx - N_KEYS;
      if (!req_found && req[scan_idx]) begin
        req_found = 1'b1;
        req_pick  = PTR_W'(scan_idx);
      end
    end
  end

  // Pointer moves past the key just served, whether it committed or aborted.
  assign gnt_next = (gnt_q == PTR_W'(N_KEYS - 1)) ? '0 : gnt_q + PTR_W'(1);

  always_comb begin
    sync1_d        = kb.key;
    ks_d           = sync1_q;
    key_level_d    = key_level_q;
    key_flag_d     = '0;
    key_rel_flag_d = '0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          gnt_d   = req_pick;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      default: begin
        if (ks_q[gnt_q] == key_level_q[gnt_q]) begin
          // Input bounced back to the debounced level: drop the attempt silently.
          state_d  = ST_IDLE;
          rr_ptr_d = gnt_next;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
          key_level_d[gnt_q] = ks_q[gnt_q];
          if (!ks_q[gnt_q]) key_flag_d[gnt_q]     = 1'b1;
          else              key_rel_flag_d[gnt_q] = 1'b1;
          rr_ptr_d = gnt_next;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= '1;
      ks_q           <= '1;
      key_level_q    <= '1;
      key_flag_q     <= '0;
      key_rel_flag_q <= '0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      gnt_q          <= '0;
      rr_ptr_q       <= '0;
    end else begin
      sync1_q        <= sync1_d;
      ks_q           <= ks_d;
      key_level_q    <= key_level_d;
      key_flag_q     <= key_flag_d;
      key_rel_flag_q <= key_rel_flag_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign kb.key_level    = key_level_q;
  assign kb.key_flag     = key_flag_q;
  assign kb.key_rel_flag = key_rel_flag_q;
  assign kb.busy         = (state_q == ST_DEBOUNCE);

endmodule
